// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared types and constants for the register-file
// write-port arbiter.
//   arb_state_t  : arbiter FSM state (free arbitration / burst-owned port)
//   PC_REG_ADDR  : architectural PC register; writes to it go to the PC path
//   MAX_REQ      : largest supported requester count (grant_id is 2 bits)
package regfile_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam logic [3:0] PC_REG_ADDR = 4'hF;
  localparam int         MAX_REQ     = 4;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: combinational "first set request at or after ptr, with wrap".
// Ports:
//   req [N-1:0] : request vector
//   ptr [1:0]   : search start index (must be < N; tie to 0 for fixed priority)
//   gnt [N-1:0] : one-hot winner (all zero when no request)
//   idx [1:0]   : winner index (0 when no request)
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [2:0]     pos;
  logic           found;

  always_comb begin
    // Rotate so the pointer position lands at bit 0; the first set bit of
    // rot at offset i maps back to requester (ptr + i) mod N.
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    gnt   = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = {1'b0, ptr} + 3'(i);
        if (pos >= 3'(N)) pos = pos - 3'(N);
        idx   = pos[1:0];
      end
    end
    if (found) gnt = N'(1) << idx;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file's single write port among
// NUM_REQ writeback requesters and registers the winning write one cycle
// ahead of the register file's negedge write.
//   clk, rst_n           : clock, async active-low reset
//   req_valid/addr/data  : per-requester write request (packed, i at [i*W +: W])
//   req_lock             : request opens/continues a locked burst
//   req_ready            : one-hot grant, transfer on valid & ready
//   rf_we/rf_wa/rf_wd    : registered register-file write (never R15)
//   pc_we/pc_wd          : registered R15 write redirected to PC logic
//   locked               : a burst currently owns the port
//   grant_id             : index of the last accepted requester
// Build option: define WB_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) with no pointer register.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_wa,
  output logic [DATA_W-1:0]         rf_wd,
  output logic                      pc_we,
  output logic [DATA_W-1:0]         pc_wd,
  output logic                      locked,
  output logic [1:0]                grant_id
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG_ADDR);

  arb_state_t         state;
  logic [1:0]         owner;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [1:0]         pick_idx;

  logic [1:0]         acc_idx;
  logic               acc;
  logic               acc_lock;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic               acc_is_pc;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant: free arbitration when idle, only the burst owner when locked.
  always_comb begin
    if (state == ARB_LOCKED) begin
      req_ready = req_valid & (NUM_REQ'(1) << owner);
      acc_idx   = owner;
    end else begin
      req_ready = pick_gnt;
      acc_idx   = pick_idx;
    end
    acc = |req_ready;
  end

  // Mux the accepted requester's payload.
  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    acc_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_idx == 2'(i)) begin
        acc_addr = req_addr[i*ADDR_W +: ADDR_W];
        acc_data = req_data[i*DATA_W +: DATA_W];
        acc_lock = req_lock[i];
      end
    end
    acc_is_pc = (acc_addr == PC_ADDR);
  end

`ifdef WB_ARB_RR_EN
  logic [1:0] ptr_q;
  assign ptr = ptr_q;

  // Pointer moves past whoever was accepted; during a burst that is always
  // the owner, so the final beat leaves it at owner+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr_q <= '0;
    else if (acc) ptr_q <= (acc_idx == 2'(NUM_REQ-1)) ? 2'd0 : acc_idx + 2'd1;
  end
`else
  assign ptr = 2'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      pc_we    <= 1'b0;
      pc_wd    <= '0;
      grant_id <= '0;
    end else begin
      rf_we <= acc && !acc_is_pc;
      pc_we <= acc && acc_is_pc;
      if (acc) begin
        grant_id <= acc_idx;
        if (acc_is_pc) pc_wd <= acc_data;
        else begin
          rf_wa <= acc_addr;
          rf_wd <= acc_data;
        end
        case (state)
          ARB_IDLE: if (acc_lock) begin
            state <= ARB_LOCKED;
            owner <= acc_idx;
          end
          ARB_LOCKED: if (!acc_lock) state <= ARB_IDLE;
          default: state <= ARB_IDLE;
        endcase
      end
    end
  end

  assign locked = (state == ARB_LOCKED);

endmodule
